aes_key_expander_mk: RTL and testbench

- Multi-key-size, multi-context AES key-expansion engine. Successor to the fixed AES-128, ten-subkey expander.
- Accepts a 128-, 192- or 256-bit cipher key and generates one 32-bit schedule word per cycle per FIPS-197.
- Stores the full schedule (44/52/60 words) in one of NUM_SLOTS independent key contexts.
- Exposes a registered random-access round-key read port. The cipher datapath reads any round key of any valid slot, including while a different slot is being expanded.

---
 rtl/aes_key_expander_mk.sv | 161 ++++++++++++++++
 tb/tb_aes_key_expander_mk.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander_mk.sv
// Multi-context AES-128/192/256 key expander. It produces one FIPS-197 schedule word per cycle into
// per-slot storage, and a registered round-key read port serves any completed slot.
module aes_key_expander_mk #(
    parameter int NUM_SLOTS = 2,
    parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 HCLK,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           key_mode,
    input  logic [SLOT_W-1:0]    slot,
    input  logic [255:0]         key_in,
    output logic                 busy,
    output logic                 done,
    output logic                 start_err,
    output logic [NUM_SLOTS-1:0] valid,
    input  logic [SLOT_W-1:0]    rd_slot,
    input  logic [3:0]           rd_round,
    output logic [127:0]         rd_key,
    output logic                 rd_err
);

    typedef enum logic {IDLE, EXPAND} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t              state, state_nxt;
    logic [5:0]          i_r;
    logic [2:0]          j_r;        // i mod Nk, tracked incrementally
    logic [7:0]          rcon_r;
    logic [31:0]         hist [8];   // hist[k] = w[i-1-k]
    logic [31:0]         key_w [8];
    logic [2:0]          nkm1_r;
    logic [3:0]          nr_r;
    logic [SLOT_W-1:0]   slot_r;
    logic [31:0]         mem [NUM_SLOTS][64];
    logic [3:0]          slot_nr [NUM_SLOTS];

    logic                mode_ok, slot_ok, accept, reject, last, key_phase;
    logic [31:0]         prev, sub_in, sub_out, t, new_word;
    logic                rd_ok;
    logic [SLOT_W-1:0]   rd_idx;
    logic [5:0]          rd_base;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mode_ok   = (key_mode != 2'd3);
        slot_ok   = (32'(slot) < 32'(NUM_SLOTS));
        accept    = (state == IDLE) && start && mode_ok && slot_ok;
        reject    = (state == IDLE) && start && !(mode_ok && slot_ok);
        last      = (state == EXPAND) && (i_r == {nr_r, 2'b11});
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXPAND;
            EXPAND:  if (last)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One shared SubWord: rotated input on Nk boundaries, plain input for the AES-256 mid-block step.
    always_comb begin
        key_phase = (i_r[5:3] == 3'd0) && (i_r[2:0] <= nkm1_r);
        prev      = hist[0];
        sub_in    = (j_r == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        sub_out   = sub_word(sub_in);
        if (j_r == 3'd0)
            t = sub_out ^ {rcon_r, 24'h0};
        else if (nkm1_r == 3'd7 && j_r == 3'd4)
            t = sub_out;
        else
            t = prev;
        new_word  = key_phase ? key_w[i_r[2:0]] : (hist[nkm1_r] ^ t);
    end

    always_ff @(posedge HCLK) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            start_err <= 1'b0;
            valid     <= '0;
            i_r       <= '0;
            j_r       <= '0;
            rcon_r    <= '0;
            for (int k = 0; k < 8; k++) hist[k] <= '0;
        end else begin
            state     <= state_nxt;
            done      <= last;
            start_err <= reject;
            if (accept) begin
                valid[slot] <= 1'b0;
                i_r         <= '0;
                j_r         <= '0;
                rcon_r      <= 8'h01;
            end
            if (state == EXPAND) begin
                i_r     <= i_r + 6'd1;
                j_r     <= (j_r == nkm1_r) ? 3'd0 : j_r + 3'd1;
                hist[0] <= new_word;
                for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
                if (!key_phase && j_r == 3'd0) rcon_r <= xtime(rcon_r);
                if (last) valid[slot_r] <= 1'b1;
            end
        end
    end

    assign busy = (state == EXPAND);

    // NOTE: storage and latched parameters carry no reset; valid[] decides whether they mean anything.
    always_ff @(posedge HCLK) begin
        if (accept) begin
            for (int k = 0; k < 8; k++) key_w[k] <= key_in[255 - 32*k -: 32];
            nkm1_r        <= 3'd3 + {key_mode, 1'b0};
            nr_r          <= 4'd10 + {1'b0, key_mode, 1'b0};
            slot_r        <= slot;
            slot_nr[slot] <= 4'd10 + {1'b0, key_mode, 1'b0};
        end
        if (state == EXPAND) mem[slot_r][i_r] <= new_word;
    end

    always_comb begin
        rd_idx  = (32'(rd_slot) < 32'(NUM_SLOTS)) ? rd_slot : '0;
        rd_ok   = (32'(rd_slot) < 32'(NUM_SLOTS)) && valid[rd_idx] && (rd_round <= slot_nr[rd_idx]);
        rd_base = {rd_round, 2'b00};
    end

    always_ff @(posedge HCLK) begin
        if (rst) begin
            rd_key <= '0;
            rd_err <= 1'b0;
        end else if (rd_ok) begin
            rd_key <= {mem[rd_idx][rd_base], mem[rd_idx][rd_base + 6'd1],
                       mem[rd_idx][rd_base + 6'd2], mem[rd_idx][rd_base + 6'd3]};
            rd_err <= 1'b0;
        end else begin
            rd_key <= '0;
            rd_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_key_expander_mk.sv
// Bench for aes_key_expander_mk: a FIPS-197 reference model feeds a scoreboard queue that a monitor
// drains every cycle, plus directed known-answer checks from the standard test vectors.
module tb_aes_key_expander_mk;
    localparam int NS = 2;
    localparam int SW = 1;

    logic          HCLK, rst, start;
    logic [1:0]    key_mode;
    logic [SW-1:0] slot, rd_slot;
    logic [255:0]  key_in;
    logic          busy, done, start_err, rd_err;
    logic [NS-1:0] valid;
    logic [3:0]    rd_round;
    logic [127:0]  rd_key;

    aes_key_expander_mk #(.NUM_SLOTS(NS)) dut (
        .HCLK(HCLK), .rst(rst), .start(start), .key_mode(key_mode), .slot(slot),
        .key_in(key_in), .busy(busy), .done(done), .start_err(start_err), .valid(valid),
        .rd_slot(rd_slot), .rd_round(rd_round), .rd_key(rd_key), .rd_err(rd_err)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model: FIPS-197 from first principles ----------------
    typedef logic [31:0] sched_t [60];
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return (b[7]) ? ((b << 1) ^ 8'h1b) : (b << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    function automatic sched_t expand(input logic [255:0] key, input int mode);
        int nk, nr;
        logic [31:0] temp;
        logic [7:0] rc;
        sched_t w;
        nk = 4 + 2*mode;
        nr = nk + 6;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                temp = w[i-1];
                if (i % nk == 0) begin
                    rc = 8'h01;
                    for (int k = 1; k < i/nk; k++) rc = xt(rc);
                    temp = subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                end else if (nk > 6 && i % nk == 4) begin
                    temp = subw(temp);
                end
                w[i] = w[i-nk] ^ temp;
            end
        end
        return w;
    endfunction

    initial begin
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_m[x] = s;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [127:0]  key;
        logic          err;
        logic          done;
        logic          serr;
        logic          busy;
        logic [NS-1:0] valid;
    } exp_t;

    exp_t   exp_q [$];
    logic   mv [NS];
    int     mnr [NS];
    sched_t msched [NS];
    sched_t mpend;
    int     mremain, mcur, mcur_nr;
    bit     mbusy;
    int     model_dones = 0;
    int     dut_dones = 0;

    // Model observes the same inputs the DUT samples at each rising edge.
    initial begin
        exp_t e;
        int   rs, rr;
        mbusy = 0;
        for (int k = 0; k < NS; k++) begin mv[k] = 0; mnr[k] = 0; end
        forever begin
            @(posedge HCLK);
            e = '0;
            if (rst) begin
                mbusy = 0;
                for (int k = 0; k < NS; k++) mv[k] = 0;
            end else begin
                rs = int'(rd_slot);
                rr = int'(rd_round);
                if (rs < NS && mv[rs] && rr <= mnr[rs])
                    e.key = {msched[rs][4*rr], msched[rs][4*rr+1], msched[rs][4*rr+2], msched[rs][4*rr+3]};
                else
                    e.err = 1'b1;
                if (mbusy) begin
                    mremain--;
                    if (mremain == 0) begin
                        e.done = 1'b1;
                        mv[mcur] = 1;
                        msched[mcur] = mpend;
                        mnr[mcur] = mcur_nr;
                        mbusy = 0;
                        model_dones++;
                    end
                end else if (start) begin
                    if (key_mode == 2'd3 || int'(slot) >= NS) begin
                        e.serr = 1'b1;
                    end else begin
                        mbusy   = 1;
                        mcur    = int'(slot);
                        mcur_nr = 10 + 2*int'(key_mode);
                        mremain = 4*(mcur_nr + 1);
                        mv[mcur] = 0;
                        mpend   = expand(key_in, int'(key_mode));
                    end
                end
                e.busy = mbusy;
            end
            for (int k = 0; k < NS; k++) e.valid[k] = mv[k];
            exp_q.push_back(e);
        end
    end

    initial begin
        exp_t got;
        forever begin
            @(negedge HCLK);
            if (exp_q.size() > 0) begin
                got = exp_q.pop_front();
                dut_dones += int'(done);
                check("rd_key",    rd_key,            got.key);
                check("rd_err",    128'(rd_err),      128'(got.err));
                check("done",      128'(done),        128'(got.done));
                check("start_err", 128'(start_err),   128'(got.serr));
                check("busy",      128'(busy),        128'(got.busy));
                check("valid",     128'(valid),       128'(got.valid));
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rd_fixed = 0;

    task automatic tick();
        @(posedge HCLK);
        #1;
        if (!rd_fixed) begin
            rd_slot  = SW'($urandom_range(0, NS-1));
            rd_round = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic start_exp(input int mode, input int s, input logic [255:0] key);
        start = 1'b1; key_mode = 2'(mode); slot = SW'(s); key_in = key;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lat);
        int n;
        n = lat + 6;
        for (int k = 1; k <= lat + 5; k++) begin
            tick();
            if (done) begin n = k; break; end
        end
        check(name, 128'(n), 128'(lat));
    endtask

    task automatic kat(input string name, input int s, input int r, input logic [127:0] exp, input logic err);
        rd_fixed = 1; rd_slot = SW'(s); rd_round = 4'(r);
        tick();
        check(name, rd_key, exp);
        check({name, "_err"}, 128'(rd_err), 128'(err));
        rd_fixed = 0;
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; key_mode = 2'd0; slot = '0; key_in = '0;
        rd_slot = '0; rd_round = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_busy",  128'(busy),  128'(0));
        check("reset_valid", 128'(valid), 128'(0));

        start_exp(0, 0, K128);
        wait_done("lat128", 44);
        kat("kat128_r1",  0, 1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0);
        kat("kat128_r10", 0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);
        kat("kat128_r11", 0, 11, 128'h0, 1'b1);

        start_exp(1, 1, K192);
        wait_done("lat192", 52);
        kat("kat192_r12", 1, 12, 128'he98ba06f448c773c8ecc720401002202, 1'b0);
        kat("kat192_r13", 1, 13, 128'h0, 1'b1);

        // Slot 0 stays readable while slot 1 is re-expanded with AES-256.
        rd_fixed = 1; rd_slot = 0; rd_round = 10;
        start_exp(2, 1, K256);
        for (int k = 0; k < 60; k++) begin
            tick();
            check("conc_key", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            check("conc_err", 128'(rd_err), 128'(0));
        end
        check("lat256_done", 128'(done), 128'(1));
        rd_fixed = 0;
        kat("kat256_r14", 1, 14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b0);

        start_exp(3, 0, K128);
        check("mode3_err",  128'(start_err), 128'(1));
        check("mode3_busy", 128'(busy),      128'(0));
        tick();
        check("mode3_pulse", 128'(start_err), 128'(0));

        start_exp(0, 0, K128);
        repeat (10) tick();
        start_exp(2, 1, K256);
        check("midstart_err", 128'(start_err), 128'(0));
        wait_done("lat_midstart", 33);

        start_exp(1, 1, K192);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy",  128'(busy),  128'(0));
        check("abort_valid", 128'(valid), 128'(0));
        repeat (60) tick();
        start_exp(1, 1, K192);
        wait_done("lat192_again", 52);
        kat("kat192_again", 1, 12, 128'he98ba06f448c773c8ecc720401002202, 1'b0);

        for (int it = 0; it < 25; it++) begin
            start_exp(int'($urandom_range(0, 3)), int'($urandom_range(0, NS-1)), rand_key());
            for (int k = 0; k < int'($urandom_range(40, 70)); k++) begin
                start    = ($urandom_range(0, 15) == 0);
                key_mode = 2'($urandom_range(0, 3));
                slot     = SW'($urandom_range(0, NS-1));
                key_in   = rand_key();
                rst      = ($urandom_range(0, 199) == 0);
                tick();
            end
            start = 1'b0; rst = 1'b0;
        end
        repeat (70) tick();
        @(negedge HCLK);
        #1;
        check("done_count", 128'(dut_dones), 128'(model_dones));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got %0d vectors, expected completion", vectors);
        $fatal(1, "timeout");
    end

endmodule
